disp7_scan_n: RTL and testbench
===============================

Name: disp7_scan_n

Overview:
Parametrised multiplexed 7-segment scan driver. It is the next generation of the fixed 8-digit scanner. It drives DIGITS common-anode digits from a packed hex bus and adds the following:
- double-buffered (tear-free) frame updates
- inter-digit blanking against ghosting
- 16-level PWM brightness
- per-digit blink
Sits between the player's display-formatting logic and the board's segment and anode pins.

Parameters:
DIGITS, 8, number of digits scanned (1..16)
DWELL_W, 16, ON phase per digit lasts 2^DWELL_W clk cycles (DWELL_W >= 4)
BLANK_CYC, 64, clk cycles with all anodes off between digits (>= 1)
BLINK_W, 6, blink half-period is 2^(BLINK_W-1) frames

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
hex_bus  in  4*DIGITS  digit i value = hex_bus[4i+3:4i]; digit 0 is rightmost
dp_in  in  DIGITS  decimal point request per digit, 1 = lit
en_mask  in  DIGITS  1 = digit enabled, 0 = always dark
blink_mask  in  DIGITS  1 = digit blinks
brightness  in  4  PWM level; 15 = full, 0 = 1/16 duty
load  in  1  single-cycle strobe; captures hex_bus/dp_in/en_mask/blink_mask into shadow registers
seg  out  8  active-low segments: seg[7] = dp, seg[6:0] = g,f,e,d,c,b,a
an  out  DIGITS  active-low anode enables
frame_start  out  1  one-cycle pulse when digit 0 enters ON

Behaviour:
- Reset (async, rst_n=0):
  - an = all 1, seg = 8'hFF, frame_start = 0.
  - Shadow and active registers cleared to 0, so all digits are disabled.
  - idx = 0, state = ON, dwell counter = 0, frame counter = 0.
- Register stages:
  - load=1 copies inputs into the shadow registers on that edge.
  - The shadow copies into the active registers only on the cycle the FSM enters ON with idx=0, the same cycle frame_start is raised internally.
  - A load on that same cycle takes effect one frame later.
  - Displayed data never changes mid-frame.
- FSM, two states:
  - ON: counts 2^DWELL_W cycles, then goes to BLANK.
  - BLANK: counts BLANK_CYC cycles with all anodes off. It then advances idx (DIGITS-1 wraps to 0) and returns to ON.
  - Frame length = DIGITS*(2^DWELL_W + BLANK_CYC) cycles.
- Anode gating in ON: an[idx] = 0 only when all of the following hold:
  - active en_mask[idx] = 1
  - dwell_cnt[DWELL_W-1:DWELL_W-4] <= brightness
  - not (blink_phase and active blink_mask[idx])
  All other anode bits are 1.
- blink_phase = frame_cnt[BLINK_W-1]. frame_cnt is BLINK_W bits, increments at each frame start and wraps naturally.
- Segments:
  - seg[6:0] is the standard hex decode of the active digit idx: 0..9, A, b, C, d, E, F.
  - Sample codes: 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, F -> 7'b0001110.
  - seg[7] = ~dp.
  - seg is 8'hFF whenever an is all 1.
- Latency: seg, an and frame_start are registered, and lag the internal state by exactly 1 clk.
- Changing brightness mid-digit takes effect on the next cycle; no glitch requirement beyond registering.
- Reset asserted mid-frame forces outputs dark immediately. The scan restarts at digit 0 with empty active data, so a load plus one frame boundary is needed before anything lights.

Optional Feature:
LZ_SUPPRESS_EN:
- Defined: leading-zero suppression.
  - A digit i is blanked (an bit 1, seg 8'hFF) when it and every enabled digit above it hold 0 with dp = 0.
  - Suppression stops at the first nonzero digit or the first digit with dp set.
  - Digit 0 is never suppressed.
  - Evaluated combinationally from the active registers at frame start and held for the frame.
- Undefined: zeros always displayed; no extra logic.

Test Plan:
1. DIGITS=4, DWELL_W=4, BLANK_CYC=2; load hex_bus=16'h1280, en_mask=4'hF, dp=0, brightness=15.
   - After the next frame_start, an cycles 1110, 1111, 1101, 1111, 1011, 1111, 0111, 1111.
   - seg sequence 1000000, 0000000, 0100100, 1111001 (dp bit 1).
   - Each ON phase is 16 cycles; each blank is 2 cycles.
2. brightness=3: per ON phase, an[idx]=0 for exactly 4 of 16 cycles (dwell_cnt 0..3), then 1 for 12 cycles.
3. Issue load mid-frame with new values: the displayed digits remain the old values until the next frame_start, then switch together.
4. blink_mask=4'b0001, BLINK_W=2: digit 0 is lit for 2 frames and dark for 2 frames, alternating. Digits 1..3 stay lit throughout.
5. Assert rst_n=0 during ON of digit 2: an=1111 and seg=8'hFF in the same cycle. After release, no digit lights until a load and a frame_start.
6. LZ_SUPPRESS_EN defined, hex_bus=16'h0030: digits 3 and 2 are dark. With dp_in=4'b0100, digit 2 shows 0 with dp lit (seg=8'b01000000) and digit 3 stays dark.

Source files
------------

// File: rtl/disp7_scan_n.sv
// Multiplexed common-anode 7-segment scanner: shadow/active frame buffering,
// inter-digit blanking, 16-level PWM and per-digit blink. Optional macro: LZ_SUPPRESS_EN.
module disp7_scan_n #(
  parameter int DIGITS    = 8,
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 64,
  parameter int BLINK_W   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] hex_bus,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   en_mask,
  input  logic [DIGITS-1:0]   blink_mask,
  input  logic [3:0]          brightness,
  input  logic                load,
  output logic [7:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                frame_start
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0]   LAST_BLK   = BLK_W'(BLANK_CYC - 1);
  localparam logic [DWELL_W-1:0] LAST_DWELL = '1;

  typedef enum logic {ST_ON = 1'b0, ST_BLANK = 1'b1} state_e;

  // Complete scan position in one struct so a checker can bind to a single signal.
  typedef struct packed {
    state_e             st;
    logic [IDX_W-1:0]   idx;
    logic [DWELL_W-1:0] dwell;
    logic [BLK_W-1:0]   blank;
  } scan_t;

  scan_t               scan_q, scan_d;
  logic                enter_frame;
  logic                fs_int;
  logic [BLINK_W-1:0]  frame_cnt;

  logic [4*DIGITS-1:0] shd_hex, act_hex;
  logic [DIGITS-1:0]   shd_dp, act_dp, shd_en, act_en, shd_blink, act_blink;

  logic [3:0]          cur_hex;
  logic                lit;
  logic [DIGITS-1:0]   an_d;
  logic [7:0]          seg_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    scan_d      = scan_q;
    enter_frame = 1'b0;
    case (scan_q.st)
      ST_ON: begin
        scan_d.dwell = scan_q.dwell + 1'b1;
        if (scan_q.dwell == LAST_DWELL) begin
          scan_d.st    = ST_BLANK;
          scan_d.blank = '0;
        end
      end
      default: begin
        scan_d.blank = scan_q.blank + 1'b1;
        if (scan_q.blank == LAST_BLK) begin
          scan_d.st    = ST_ON;
          scan_d.dwell = '0;
          if (scan_q.idx == LAST_IDX) begin
            scan_d.idx  = '0;
            enter_frame = 1'b1;
          end else begin
            scan_d.idx = scan_q.idx + 1'b1;
          end
        end
      end
    endcase
  end

  // Active data only moves on the edge that starts a frame, so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q    <= '0;
      fs_int    <= 1'b0;
      frame_cnt <= '0;
      shd_hex   <= '0;
      shd_dp    <= '0;
      shd_en    <= '0;
      shd_blink <= '0;
      act_hex   <= '0;
      act_dp    <= '0;
      act_en    <= '0;
      act_blink <= '0;
    end else begin
      scan_q <= scan_d;
      fs_int <= enter_frame;
      if (enter_frame) begin
        act_hex   <= shd_hex;
        act_dp    <= shd_dp;
        act_en    <= shd_en;
        act_blink <= shd_blink;
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (load) begin
        shd_hex   <= hex_bus;
        shd_dp    <= dp_in;
        shd_en    <= en_mask;
        shd_blink <= blink_mask;
      end
    end
  end

`ifdef LZ_SUPPRESS_EN
  logic [DIGITS-1:0] lz_supp;
  logic              lz_run;

  // Walk down from the top digit; disabled digits neither blank nor stop the run.
  always_comb begin
    lz_supp = '0;
    lz_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (act_en[i] && ((act_hex[4*i +: 4] != 4'h0) || act_dp[i])) lz_run = 1'b0;
      lz_supp[i] = lz_run && (i != 0);
    end
  end
`endif

  always_comb begin
    cur_hex = act_hex[4*scan_q.idx +: 4];
    lit = (scan_q.st == ST_ON) && act_en[scan_q.idx] &&
          (scan_q.dwell[DWELL_W-1 -: 4] <= brightness) &&
          !(frame_cnt[BLINK_W-1] && act_blink[scan_q.idx]);
`ifdef LZ_SUPPRESS_EN
    lit = lit && !lz_supp[scan_q.idx];
`endif
    an_d  = '1;
    seg_d = 8'hFF;
    if (lit) begin
      an_d[scan_q.idx] = 1'b0;
      seg_d            = {~act_dp[scan_q.idx], hex7(cur_hex)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= '1;
      seg         <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      an          <= an_d;
      seg         <= seg_d;
      frame_start <= fs_int;
    end
  end
endmodule

// File: tb/tb_disp7_scan_n.sv
// Bench for disp7_scan_n (4 digits, short dwell): position-in-frame reference model
// checked every cycle, plus hand-computed literal checks of the scan behaviour.
module tb_disp7_scan_n;
  localparam int D      = 4;
  localparam int DW     = 4;
  localparam int BC     = 2;
  localparam int BW     = 2;
  localparam int ON_LEN = 1 << DW;
  localparam int PER    = ON_LEN + BC;
  localparam int FRAME  = D * PER;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*D-1:0] hex_bus;
  logic [D-1:0]  dp_in, en_mask, blink_mask;
  logic [3:0]    brightness;
  logic          load;
  logic [7:0]    seg;
  logic [D-1:0]  an;
  logic          frame_start;

  int total = 0;
  int bad   = 0;

  disp7_scan_n #(.DIGITS(D), .DWELL_W(DW), .BLANK_CYC(BC), .BLINK_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .hex_bus(hex_bus), .dp_in(dp_in), .en_mask(en_mask),
    .blink_mask(blink_mask), .brightness(brightness), .load(load),
    .seg(seg), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Reference model: scan position derived from the number of edges since reset.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int           k;
  logic [4*D-1:0] m_shd_hex, m_act_hex;
  logic [D-1:0] m_shd_dp, m_act_dp, m_shd_en, m_act_en, m_shd_bl, m_act_bl;
  logic [D-1:0] exp_an = '1;
  logic [7:0]   exp_seg = 8'hFF;
  logic         exp_fs = 1'b0;

`ifdef LZ_SUPPRESS_EN
  function automatic bit lz_blank(input int d);
    if (d == 0) return 1'b0;
    for (int j = d; j < D; j++)
      if (m_act_en[j] && ((m_act_hex[4*j +: 4] != 4'h0) || m_act_dp[j])) return 1'b0;
    return 1'b1;
  endfunction
`endif

  initial begin
    forever begin : model_step
      int  p, d, r, fc;
      bit  lit;
      @(posedge clk);
      if (!rst_n) begin
        k = 0;
        m_shd_hex = '0; m_shd_dp = '0; m_shd_en = '0; m_shd_bl = '0;
        m_act_hex = '0; m_act_dp = '0; m_act_en = '0; m_act_bl = '0;
        exp_an = '1; exp_seg = 8'hFF; exp_fs = 1'b0;
      end else begin
        p  = k % FRAME;
        d  = p / PER;
        r  = p % PER;
        fc = (k / FRAME) % (1 << BW);
        lit = (r < ON_LEN) && m_act_en[d] && ((r >> (DW - 4)) <= int'(brightness)) &&
              !((((fc >> (BW - 1)) & 1) == 1) && m_act_bl[d]);
`ifdef LZ_SUPPRESS_EN
        lit = lit && !lz_blank(d);
`endif
        exp_an  = lit ? ~(D'(1) << d) : '1;
        exp_seg = lit ? {~m_act_dp[d], seg_tab[m_act_hex[4*d +: 4]]} : 8'hFF;
        exp_fs  = (k > 0) && (p == 0);
        k = k + 1;
        if (k % FRAME == 0) begin
          m_act_hex = m_shd_hex; m_act_dp = m_shd_dp; m_act_en = m_shd_en; m_act_bl = m_shd_bl;
        end
        if (load) begin
          m_shd_hex = hex_bus; m_shd_dp = dp_in; m_shd_en = en_mask; m_shd_bl = blink_mask;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("an_in_reset", 32'(an), 32'hF);
        chk("seg_in_reset", 32'(seg), 32'hFF);
      end else begin
        chk("an", 32'(an), 32'(exp_an));
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 400);
    chk("frame_start_seen", 32'(frame_start), 32'h1);
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] en,
                         input logic [3:0] bl);
    hex_bus = h; dp_in = dp; en_mask = en; blink_mask = bl; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    int cnt, lit0, lit3;
    rst_n = 1'b0; hex_bus = '0; dp_in = '0; en_mask = '0; blink_mask = '0;
    brightness = 4'd15; load = 1'b0;
    step(3);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_fs", 32'(frame_start), 32'h0);
    rst_n = 1'b1;

    // Basic scan of 1280 at full brightness.
    do_load(16'h1280, 4'h0, 4'hF, 4'h0);
    wait_fs();
    chk("t1_an_d0", 32'(an), 32'hE);   chk("t1_seg_d0", 32'(seg), 32'hC0);
    step(16);
    chk("t1_an_blank", 32'(an), 32'hF); chk("t1_seg_blank", 32'(seg), 32'hFF);
    step(2);
    chk("t1_an_d1", 32'(an), 32'hD);   chk("t1_seg_d1", 32'(seg), 32'h80);
    step(18);
    chk("t1_an_d2", 32'(an), 32'hB);   chk("t1_seg_d2", 32'(seg), 32'hA4);
    step(18);
    chk("t1_an_d3", 32'(an), 32'h7);   chk("t1_seg_d3", 32'(seg), 32'hF9);

    // Mid-frame load must not show until the next frame.
    do_load(16'h5555, 4'h0, 4'hF, 4'h0);
    step(5);
    chk("t3_old_an", 32'(an), 32'h7);  chk("t3_old_seg", 32'(seg), 32'hF9);
    wait_fs();
    chk("t3_new_an", 32'(an), 32'hE);  chk("t3_new_seg", 32'(seg), 32'h92);

    // PWM at brightness 3: 4 lit cycles per ON phase.
    brightness = 4'd3;
    wait_fs();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (an == 4'hE) cnt++;
      @(negedge clk);
    end
    chk("t2_lit_cycles", 32'(cnt), 32'd4);

    // Blink digit 0 over four frames.
    brightness = 4'd15;
    do_load(16'h1280, 4'h0, 4'hF, 4'h1);
    wait_fs();
    lit0 = 0; lit3 = 0;
    for (int f = 0; f < 4; f++) begin
      if (an == 4'hE) lit0++;
      step(54);
      if (an == 4'h7) lit3++;
      wait_fs();
    end
    chk("t4_d0_lit_frames", 32'(lit0), 32'd2);
    chk("t4_d3_lit_frames", 32'(lit3), 32'd4);

    // Asynchronous reset during digit 2.
    step(39);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_an_async", 32'(an), 32'hF);
    chk("t5_seg_async", 32'(seg), 32'hFF);
    chk("t5_fs_async", 32'(frame_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (an != 4'hF) cnt++;
    end
    chk("t5_dark_after_reset", 32'(cnt), 32'd0);
    do_load(16'h1280, 4'h0, 4'hF, 4'h0);
    wait_fs();
    chk("t5_relit_an", 32'(an), 32'hE);
    chk("t5_relit_seg", 32'(seg), 32'hC0);

`ifdef LZ_SUPPRESS_EN
    do_load(16'h0030, 4'h0, 4'hF, 4'h0);
    wait_fs();
    step(36);
    chk("t6_d2_dark", 32'(an), 32'hF);
    step(18);
    chk("t6_d3_dark", 32'(an), 32'hF);
    do_load(16'h0030, 4'h4, 4'hF, 4'h0);
    wait_fs();
    step(36);
    chk("t6_d2_an", 32'(an), 32'hB);
    chk("t6_d2_seg", 32'(seg), 32'h40);
    step(18);
    chk("t6_d3_dark_dp", 32'(an), 32'hF);
`endif

    // Random traffic against the model, with one asynchronous reset.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      load = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        hex_bus    = 16'($urandom);
        dp_in      = 4'($urandom);
        en_mask    = 4'($urandom);
        blink_mask = 4'($urandom);
        load       = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) brightness = 4'($urandom);
      if (c == 3000) begin
        #2 rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
    end
    load = 1'b0;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
